// File: rtl/debounce_filter.sv
// Debounce filter: synchronizes a raw asynchronous input, then follows it only after the
// synchronized level has differed from the output for stable_ticks consecutive cycles.
module debounce_filter #(
  parameter int sync_stages  = 2,  // legal range 1..4
  parameter int stable_ticks = 4   // must be >= 1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_signal,
  output logic debounced_signal,
  output logic rising_edge,
  output logic falling_edge
);

  localparam int count_w = $clog2(stable_ticks + 1);
  localparam logic [count_w-1:0] count_last = count_w'(stable_ticks - 1);
  localparam logic [count_w-1:0] count_max  = count_w'(stable_ticks);
  localparam logic [count_w-1:0] count_one  = count_w'(1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_t;

  logic [sync_stages-1:0] sync  = '0;
  state_t                 state = STABLE_LOW;
  logic [count_w-1:0]     count = '0;
  logic                   level = 1'b0;
  logic                   rise  = 1'b0;
  logic                   fall  = 1'b0;

  state_t             state_next;
  logic [count_w-1:0] count_next;
  logic               level_next;
  logic               rise_next;
  logic               fall_next;
  logic               sample;

  assign sample = sync[sync_stages-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= '0;
      state <= STABLE_LOW;
      count <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync[0] <= raw_signal;
      for (int i = 1; i < sync_stages; i++) begin
        sync[i] <= sync[i-1];
      end
      state <= state_next;
      count <= count_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Any return of sample to the current level drops back to STABLE_* with the count cleared.
  always_comb begin
    state_next = state;
    count_next = count;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state)
      STABLE_LOW: begin
        count_next = '0;
        if (sample) begin
          if (stable_ticks == 1) begin
            state_next = STABLE_HIGH;
            level_next = 1'b1;
            rise_next  = 1'b1;
          end else begin
            state_next = CHECK_HIGH;
            count_next = count_one;
          end
        end
      end
      CHECK_HIGH: begin
        if (!sample) begin
          state_next = STABLE_LOW;
          count_next = '0;
        end else if (count == count_last) begin
          state_next = STABLE_HIGH;
          count_next = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else if (count != count_max) begin
          count_next = count + count_one;
        end
      end
      STABLE_HIGH: begin
        count_next = '0;
        if (!sample) begin
          if (stable_ticks == 1) begin
            state_next = STABLE_LOW;
            level_next = 1'b0;
            fall_next  = 1'b1;
          end else begin
            state_next = CHECK_LOW;
            count_next = count_one;
          end
        end
      end
      CHECK_LOW: begin
        if (sample) begin
          state_next = STABLE_HIGH;
          count_next = '0;
        end else if (count == count_last) begin
          state_next = STABLE_LOW;
          count_next = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else if (count != count_max) begin
          count_next = count + count_one;
        end
      end
      default: begin
        state_next = STABLE_LOW;
        count_next = '0;
        level_next = 1'b0;
      end
    endcase
  end

  assign debounced_signal = level;
  assign rising_edge      = rise;
  assign falling_edge     = fall;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: two instances (2/4 and 1/1) checked every cycle against a
// run-length model of the filtering rule, plus directed latency, glitch and reset cases.
module tb_debounce_filter;

  localparam int SA = 2;
  localparam int TA = 4;
  localparam int SB = 1;
  localparam int TB = 1;
  localparam int DEPTH = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic deb_a, rise_a, fall_a;
  logic deb_b, rise_b, fall_b;

  int total = 0;
  int bad = 0;

  // Model state: raw history per edge, output level and run length of disagreeing samples.
  bit hist_a[DEPTH];
  bit hist_b[DEPTH];
  int edge_n = 0;
  int valid_from = 0;
  bit out_a = 1'b0, out_b = 1'b0;
  bit exp_rise_a = 1'b0, exp_fall_a = 1'b0, exp_rise_b = 1'b0, exp_fall_b = 1'b0;
  int run_a = 0, run_b = 0;

  always #5 clock = ~clock;

  debounce_filter #(.sync_stages(SA), .stable_ticks(TA)) dut_a (
    .clock(clock),
    .reset(reset),
    .raw_signal(raw_a),
    .debounced_signal(deb_a),
    .rising_edge(rise_a),
    .falling_edge(fall_a)
  );

  debounce_filter #(.sync_stages(SB), .stable_ticks(TB)) dut_b (
    .clock(clock),
    .reset(reset),
    .raw_signal(raw_b),
    .debounced_signal(deb_b),
    .rising_edge(rise_b),
    .falling_edge(fall_b)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  // Sample seen by the filter at this edge is raw from 'delay' edges ago, or 0 if a reset
  // happened since then.
  function automatic bit delayedA(input int delay);
    if (edge_n - delay < valid_from) return 1'b0;
    return hist_a[(edge_n - delay) % DEPTH];
  endfunction

  function automatic bit delayedB(input int delay);
    if (edge_n - delay < valid_from) return 1'b0;
    return hist_b[(edge_n - delay) % DEPTH];
  endfunction

  task automatic stepModel();
    bit sa, sb;
    exp_rise_a = 1'b0;
    exp_fall_a = 1'b0;
    exp_rise_b = 1'b0;
    exp_fall_b = 1'b0;
    hist_a[edge_n % DEPTH] = raw_a;
    hist_b[edge_n % DEPTH] = raw_b;
    if (reset) begin
      valid_from = edge_n + 1;
      out_a = 1'b0;
      out_b = 1'b0;
      run_a = 0;
      run_b = 0;
    end else begin
      sa = delayedA(SA);
      sb = delayedB(SB);
      run_a = (sa != out_a) ? run_a + 1 : 0;
      if (run_a == TA) begin
        out_a = ~out_a;
        run_a = 0;
        exp_rise_a = out_a;
        exp_fall_a = ~out_a;
      end
      run_b = (sb != out_b) ? run_b + 1 : 0;
      if (run_b == TB) begin
        out_b = ~out_b;
        run_b = 0;
        exp_rise_b = out_b;
        exp_fall_b = ~out_b;
      end
    end
    edge_n++;
  endtask

  task automatic checkOutput();
    check("deb_a", deb_a, out_a);
    check("rise_a", rise_a, exp_rise_a);
    check("fall_a", fall_a, exp_fall_a);
    check("excl_a", rise_a & fall_a, 1'b0);
    check("deb_b", deb_b, out_b);
    check("rise_b", rise_b, exp_rise_b);
    check("fall_b", fall_b, exp_fall_b);
    check("excl_b", rise_b & fall_b, 1'b0);
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit b);
    reset = r;
    raw_a = a;
    raw_b = b;
    @(posedge clock);
    stepModel();
    #1;
    checkOutput();
  endtask

  // Holds raw_a at 'a' and counts edges until the requested strobe; -1 if it never comes.
  task automatic ticksUntil(input bit a, input bit want_rise, output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, a, 1'b0);
      if (want_rise ? rise_a : fall_a) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int rises, falls;
    bit seen_high;
    int left_a, left_b;
    bit la, lb;

    $display("[TB] reset with raw high");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      check("reset_deb", deb_a, 1'b0);
      check("reset_rise", rise_a, 1'b0);
    end
    ticksUntil(1'b1, 1'b1, n);
    checkInt("latency_after_reset", n, SA + TA);
    check("level_after_rise", deb_a, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    check("rise_one_cycle", rise_a, 1'b0);

    $display("[TB] clean fall then rise/fall");
    ticksUntil(1'b0, 1'b0, n);
    checkInt("fall_latency", n, SA + TA);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    ticksUntil(1'b1, 1'b1, n);
    checkInt("rise_latency", n, SA + TA);
    repeat (14) applyStimulus(1'b0, 1'b1, 1'b0);
    ticksUntil(1'b0, 1'b0, n);
    checkInt("fall_latency2", n, SA + TA);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] glitch rejection");
    seen_high = 1'b0;
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      seen_high |= deb_a | rise_a;
    end
    repeat (10) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      seen_high |= deb_a | rise_a;
    end
    check("glitch3_rejected", seen_high, 1'b0);
    rises = 0;
    falls = 0;
    repeat (4) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      rises += int'(rise_a);
      falls += int'(fall_a);
    end
    repeat (12) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      rises += int'(rise_a);
      falls += int'(fall_a);
    end
    checkInt("pulse4_rises", rises, 1);
    checkInt("pulse4_falls", falls, 1);

    $display("[TB] bounce restarts count");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    ticksUntil(1'b1, 1'b1, n);
    checkInt("bounce_latency", n, SA + TA);

    $display("[TB] reset during check-low");
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    check("high_before_reset", deb_a, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("reset_clears_level", deb_a, 1'b0);
    check("reset_no_fall", fall_a, 1'b0);
    seen_high = 1'b0;
    repeat (10) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      seen_high |= deb_a | rise_a | fall_a;
    end
    check("quiet_after_reset", seen_high, 1'b0);

    $display("[TB] single-tick instance pulse");
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("b_not_yet", deb_b, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    check("b_high", deb_b, 1'b1);
    check("b_rise", rise_b, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    check("b_low_again", deb_b, 1'b0);
    check("b_fall", fall_b, 1'b1);
    check("b_rise_gone", rise_b, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] random runs");
    left_a = 0;
    left_b = 0;
    la = 1'b0;
    lb = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (left_a == 0) begin
        la = ~la;
        left_a = $urandom_range(1, 7);
      end
      if (left_b == 0) begin
        lb = ~lb;
        left_b = $urandom_range(1, 3);
      end
      applyStimulus($urandom_range(0, 99) == 0, la, lb);
      left_a--;
      left_b--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
